i2c_slave: RTL and testbench

//  - Fixed-address I2C target, 7-bit addressing. Single 8-bit data register, readable and writable by a bus master.
//  - Sits between the board-level open-drain SDA/SCL pads and internal logic.
//  - Oversamples the bus with a fast system clock.
//  - Never drives a line high and never stretches SCL.

---
 rtl/i2c_slave.sv | 155 +++++++++++++++
 tb/tb_i2c_slave.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - fixed-address I2C target with a single read/write data register.
// Oversamples open-drain SDA/SCL on the system clock; only ever pulls SDA low, never touches SCL.
module i2c_slave #(
  parameter logic [6:0] my_address       = 7'h00,
  parameter logic [7:0] data_buffer_init = 8'h00
) (
  input  logic clock,
  input  logic reset,
  inout  wire  SDA,
  inout  wire  SCL
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ACK_A, ST_TX, ST_MACK, ST_RX, ST_ACK_W
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  sda_sync_q, sda_sync_d, scl_sync_q, scl_sync_d;
  logic        sda_prev_q, sda_prev_d, scl_prev_q, scl_prev_d;
  logic        sda_drive_q, sda_drive_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_buffer_q, data_buffer_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        byte_full_q, byte_full_d;
  logic        nack_q, nack_d;

  logic sda_in, scl_in, scl_rise, scl_fall, start_det, stop_det, addr_hit;

  assign SDA = sda_drive_q ? 1'b0 : 1'bz;
  assign SCL = 1'bz;

  always_comb begin
    sda_sync_d = {sda_sync_q[0], SDA};
    scl_sync_d = {scl_sync_q[0], SCL};
    sda_prev_d = sda_sync_q[1];
    scl_prev_d = scl_sync_q[1];
  end

  assign sda_in    = sda_sync_q[1];
  assign scl_in    = scl_sync_q[1];
  assign scl_rise  = scl_in & ~scl_prev_q;
  assign scl_fall  = ~scl_in & scl_prev_q;
  assign start_det = scl_in & scl_prev_q & sda_prev_q & ~sda_in;
  assign stop_det  = scl_in & scl_prev_q & ~sda_prev_q & sda_in;
  assign addr_hit  = (shift_q[7:1] == my_address);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Bus conditions win over any per-bit action in the same cycle.
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d = ST_ADDR;
    end else begin
      case (state_q)
        ST_ADDR:  if (scl_fall && byte_full_q) state_d = addr_hit ? ST_ACK_A : ST_IDLE;
        ST_ACK_A: if (scl_fall) state_d = shift_q[0] ? ST_TX : ST_RX;
        ST_TX:    if (scl_fall && (bit_cnt_q == 3'd7)) state_d = ST_MACK;
        ST_MACK:  if (scl_fall) state_d = nack_q ? ST_IDLE : ST_TX;
        ST_RX:    if (scl_fall && byte_full_q) state_d = ST_ACK_W;
        ST_ACK_W: if (scl_fall) state_d = ST_RX;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sda_drive_d   = sda_drive_q;
    shift_d       = shift_q;
    data_buffer_d = data_buffer_q;
    bit_cnt_d     = bit_cnt_q;
    byte_full_d   = byte_full_q;
    nack_d        = nack_q;
    if (stop_det || start_det) begin
      sda_drive_d = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_full_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_RX: begin
          // byte_full marks the 8th rise so the fall right after START is ignored.
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_in};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_full_d = 1'b1;
          end else if (scl_fall && byte_full_q) begin
            byte_full_d = 1'b0;
            if (state_q == ST_ADDR) begin
              sda_drive_d = addr_hit;
            end else begin
              data_buffer_d = shift_q;
              sda_drive_d   = 1'b1;
            end
          end
        end
        ST_ACK_A: if (scl_fall) begin
          bit_cnt_d   = 3'd0;
          sda_drive_d = shift_q[0] ? ~data_buffer_q[7] : 1'b0;
        end
        ST_TX: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_drive_d = 1'b0;
            bit_cnt_d   = 3'd0;
          end else begin
            bit_cnt_d   = bit_cnt_q + 3'd1;
            sda_drive_d = ~data_buffer_q[3'd6 - bit_cnt_q];
          end
        end
        ST_MACK: begin
          if (scl_rise) begin
            nack_d = sda_in;
          end else if (scl_fall) begin
            bit_cnt_d   = 3'd0;
            sda_drive_d = nack_q ? 1'b0 : ~data_buffer_q[7];
          end
        end
        ST_ACK_W: if (scl_fall) sda_drive_d = 1'b0;
        default:  sda_drive_d = 1'b0;
      endcase
    end
  end

  // Synchronizers reset to the idle-high bus level so reset release creates no edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sda_sync_q    <= 2'b11;
      scl_sync_q    <= 2'b11;
      sda_prev_q    <= 1'b1;
      scl_prev_q    <= 1'b1;
      sda_drive_q   <= 1'b0;
      shift_q       <= 8'h00;
      data_buffer_q <= data_buffer_init;
      bit_cnt_q     <= 3'd0;
      byte_full_q   <= 1'b0;
      nack_q        <= 1'b0;
    end else begin
      sda_sync_q    <= sda_sync_d;
      scl_sync_q    <= scl_sync_d;
      sda_prev_q    <= sda_prev_d;
      scl_prev_q    <= scl_prev_d;
      sda_drive_q   <= sda_drive_d;
      shift_q       <= shift_d;
      data_buffer_q <= data_buffer_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_full_q   <= byte_full_d;
      nack_q        <= nack_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - bit-banged I2C master with a queued scoreboard checking SDA on every SCL pulse.
module tb_i2c_slave;

  localparam logic [6:0] MY_ADDR = 7'h56;
  localparam logic [7:0] INIT    = 8'hA5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic m_sda_oe = 1'b0;
  logic m_scl_oe = 1'b0;
  wire  SDA, SCL;

  pullup (SDA);
  pullup (SCL);
  assign SDA = m_sda_oe ? 1'b0 : 1'bz;
  assign SCL = m_scl_oe ? 1'b0 : 1'bz;

  i2c_slave #(.my_address(MY_ADDR), .data_buffer_init(INIT)) dut (
    .clock(clock),
    .reset(reset),
    .SDA  (SDA),
    .SCL  (SCL)
  );

  always #7 clock = ~clock;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic       exp_q[$];
  logic       chk_q[$];
  string      nm_q[$];
  logic [7:0] wdata_q[$];
  logic       mon_en = 1'b0;
  logic [7:0] model_reg;

  task automatic check(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: sda=%0b expected=%0b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic chk, input logic exp, input string nm);
    chk_q.push_back(chk);
    exp_q.push_back(exp);
    nm_q.push_back(nm);
  endtask

  // One SCL pulse; the expected wired-AND bus level is only checked when the master releases SDA.
  task automatic send_bit(input logic mbit, input logic slave_exp, input string nm);
    #25 m_sda_oe = ~mbit;
    push_exp(mbit, slave_exp, nm);
    #25 m_scl_oe = 1'b0;
    #50 m_scl_oe = 1'b1;
  endtask

  task automatic start_cond();
    if (m_scl_oe) begin
      #25 m_sda_oe = 1'b0;
      push_exp(1'b0, 1'b1, "rs_setup");
      #25 m_scl_oe = 1'b0;
      #50;
    end else begin
      #50;
    end
    m_sda_oe = 1'b1;
    #50 m_scl_oe = 1'b1;
  endtask

  task automatic stop_cond();
    #25 m_sda_oe = 1'b1;
    push_exp(1'b0, 1'b1, "stop_setup");
    #25 m_scl_oe = 1'b0;
    #50 m_sda_oe = 1'b0;
    #100;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b1, "wr_bit_released");
    send_bit(1'b1, exp_ack, nm);
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic last);
    for (int i = 7; i >= 0; i--) send_bit(1'b1, exp[i], "rd_bit");
    if (last) send_bit(1'b1, 1'b1, "nack_released");
    else      send_bit(1'b0, 1'b0, "master_ack");
  endtask

  // Reference model: the register answers only its own address, ACKs every byte written,
  // keeps the last byte written, and repeats that byte on every read.
  task automatic xfer(input logic [6:0] a, input logic rw, input int n, input logic do_stop);
    logic       hit;
    logic [7:0] b;
    hit = (a == MY_ADDR);
    start_cond();
    write_byte({a, rw}, hit ? 1'b0 : 1'b1, "addr_ack");
    for (int k = 0; k < n; k++) begin
      if (!rw) begin
        b = wdata_q.pop_front();
        write_byte(b, hit ? 1'b0 : 1'b1, "data_ack");
        if (hit) model_reg = b;
      end else begin
        read_byte(hit ? model_reg : 8'hFF, k == n - 1);
      end
    end
    if (do_stop) stop_cond();
  endtask

  initial begin
    logic e, c;
    string nm;
    wait (mon_en);
    forever begin
      @(posedge SCL);
      #25;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: queued=0 required>=1 at t=%0t", $time);
      end else begin
        e  = exp_q.pop_front();
        c  = chk_q.pop_front();
        nm = nm_q.pop_front();
        if (c) check(nm, SDA, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded bound");
    $fatal(1);
  end

  initial begin
    logic [6:0] a;
    logic       rw;
    int         n;
    logic [7:0] addr_w;

    model_reg = INIT;
    repeat (5) @(posedge clock);
    check("reset_sda", SDA, 1'b1);
    check("reset_scl", SCL, 1'b1);
    #3 reset = 1'b1;
    mon_en = 1'b1;
    repeat (20) @(negedge clock);
    check("idle_sda", SDA, 1'b1);
    check("idle_scl", SCL, 1'b1);

    xfer(MY_ADDR, 1'b1, 2, 1'b1);
    check("after_nack_sda", SDA, 1'b1);

    wdata_q.push_back(8'h3C);
    xfer(MY_ADDR, 1'b0, 1, 1'b1);
    xfer(MY_ADDR, 1'b1, 1, 1'b1);

    wdata_q.push_back(8'hFF);
    wdata_q.push_back(8'hFF);
    xfer(7'h46, 1'b0, 2, 1'b1);
    check("wrong_addr_idle_sda", SDA, 1'b1);

    addr_w = {MY_ADDR, 1'b0};
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(addr_w[i], 1'b1, "rst_addr_bit");
    #25 m_sda_oe = 1'b0;
    push_exp(1'b1, 1'b0, "rst_pre_ack");
    #25 m_scl_oe = 1'b0;
    #30 reset = 1'b0;
    #1 check("reset_mid_release", SDA, 1'b1);
    model_reg = INIT;
    #40 reset = 1'b1;
    #30 m_scl_oe = 1'b1;
    stop_cond();
    xfer(MY_ADDR, 1'b1, 1, 1'b1);

    for (int t = 0; t < 25; t++) begin
      a  = ($urandom_range(0, 1) == 1) ? MY_ADDR : 7'($urandom_range(0, 127));
      rw = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 3);
      if (!rw) for (int k = 0; k < n; k++) wdata_q.push_back(8'($urandom_range(0, 255)));
      xfer(a, rw, n, 1'($urandom_range(0, 1)));
    end
    if (m_scl_oe) stop_cond();
    xfer(MY_ADDR, 1'b1, 1, 1'b1);

    #200;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: queued=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
